cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have ports clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-002 The block SHALL have ports reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have port i_pmem_read, input, 1, I-cache line-fill request, held high until i_pmem_resp.
REQ-004 The block SHALL have port i_pmem_address, input, 16 (lc3b_word), I-cache line address, stable while requesting.
REQ-005 The block SHALL have port i_pmem_rdata, output, 128 (lc3b_line), fill data to the I-cache.
REQ-006 The block SHALL have port i_pmem_resp, output, 1, one-cycle completion pulse to the I-cache.
REQ-007 The block SHALL have ports d_pmem_read and d_pmem_write, input, 1 each, D-cache fill and writeback requests, held until d_pmem_resp.
REQ-008 The block SHALL have port d_pmem_address, input, 16, D-cache line address.
REQ-009 The block SHALL have port d_pmem_wdata, input, 128, D-cache writeback line.
REQ-010 The block SHALL have port d_pmem_rdata, output, 128, fill data to the D-cache.
REQ-011 The block SHALL have port d_pmem_resp, output, 1, completion pulse to the D-cache.
REQ-012 The block SHALL have ports pmem_read and pmem_write, output, 1 each, physical-memory commands.
REQ-013 The block SHALL have ports pmem_address (output, 16), pmem_wdata (output, 128), pmem_rdata (input, 128) and pmem_resp (input, 1), the shared physical-memory port.

Function
REQ-014 The FSM SHALL have three states: IDLE, I_SERVE and D_SERVE.
REQ-015 The FSM SHALL make grant decisions only in IDLE.
- If exactly one side is requesting, that side is granted at the next edge.
- If neither side is requesting, the FSM stays in IDLE.
REQ-016 On a tie (i_pmem_read and (d_pmem_read or d_pmem_write)), the grant SHALL go to the side not recorded in the last_grant register (round-robin).
REQ-017 last_grant SHALL update to the granted side on every IDLE->SERVE transition.
REQ-018 On entering D_SERVE, the block SHALL latch d_op_write = d_pmem_write; if d_pmem_read and d_pmem_write are both high, the operation is a write.
REQ-019 In I_SERVE: pmem_read=1, pmem_write=0, pmem_address=i_pmem_address.
REQ-020 In D_SERVE: pmem_read=~d_op_write, pmem_write=d_op_write, pmem_address=d_pmem_address, pmem_wdata=d_pmem_wdata.
REQ-021 In IDLE: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
REQ-022 i_pmem_resp SHALL equal pmem_resp in I_SERVE and 0 otherwise; d_pmem_resp SHALL equal pmem_resp in D_SERVE and 0 otherwise.
REQ-023 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata at all times.
REQ-024 A SERVE state SHALL return to IDLE at the edge where pmem_resp=1.
- The earliest re-grant is therefore two cycles after a response.
- The latency from a request seen in IDLE to the pmem command is one cycle.
REQ-025 If a requester drops its request in mid-service, the block SHALL stay in SERVE until pmem_resp, driving the latched command (protocol violation tolerated).
REQ-026 pmem_resp received in IDLE SHALL be ignored, and no requester response SHALL be generated.
REQ-027 The block SHALL never assert pmem_read and pmem_write together, and never grant both sides in the same cycle.

Reset
REQ-028 On reset, the block SHALL go to IDLE, with last_grant=I and d_op_write=0.
- All outputs take their IDLE values on the next cycle.
- Reset takes effect even mid-service; an in-flight response is dropped.

Structure
REQ-029 The types lc3b_word and lc3b_line (128-bit) and the state enum SHALL be defined in lc3b_types.
REQ-030 The block SHALL be a single module with no sub-modules: FSM, last_grant and d_op_write registers, plus an output mux.

Verification
REQ-031 The bench SHALL cover this single I request: i_pmem_read=1 with addr 0x1230; pmem_read=1 and addr 0x1230 the next cycle; pmem_resp with rdata 0xA5..A5 produces i_pmem_resp=1 with matching data, and the FSM returns to IDLE.
REQ-032 The bench SHALL cover a first tie after reset: I and D (read, 0x4000) requesting together; D is granted first and I is granted two cycles after D's resp.
REQ-033 The bench SHALL cover alternation: I and D requesting continuously over 4 transactions; grants go D, I, D, I, with pmem_read and pmem_write never both high.
REQ-034 The bench SHALL cover a D writeback: d_pmem_read=d_pmem_write=1 with wdata 0x0F..0F; pmem_write=1, pmem_read=0 and pmem_wdata matches until resp.
REQ-035 The bench SHALL cover reset mid-service: reset asserted in I_SERVE, then pmem_resp=1; i_pmem_resp stays 0 and pmem_read=0 the following cycle.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory subsystem.
//   lc3b_word   : 16-bit address/data word
//   lc3b_line   : 128-bit cache line
//   arb_state_e : cache arbiter FSM states
//   grant_e     : which cache side was granted the memory port
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIServe = 2'd1,
        StDServe = 2'd2
    } arb_state_e;

    typedef enum logic {
        GrantI = 1'b0,
        GrantD = 1'b1
    } grant_e;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, cache arbiter and physical memory.
//   I-cache side : i_pmem_read, i_pmem_address -> arbiter; i_pmem_rdata, i_pmem_resp <- arbiter
//   D-cache side : d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata -> arbiter;
//                  d_pmem_rdata, d_pmem_resp <- arbiter
//   Memory side  : pmem_read, pmem_write, pmem_address, pmem_wdata <- arbiter;
//                  pmem_rdata, pmem_resp -> arbiter
// Modports: slave is the arbiter's view, master is the view of the caches plus memory.
interface cache_arbiter_if;
    import lc3b_types::*;

    logic     i_pmem_read;
    lc3b_word i_pmem_address;
    lc3b_line i_pmem_rdata;
    logic     i_pmem_resp;

    logic     d_pmem_read;
    logic     d_pmem_write;
    lc3b_word d_pmem_address;
    lc3b_line d_pmem_wdata;
    lc3b_line d_pmem_rdata;
    logic     d_pmem_resp;

    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    lc3b_line pmem_rdata;
    logic     pmem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates the single physical-memory port between the I-cache and D-cache.
// Grants are made only from idle; ties alternate via a last-grant register. The D-side
// operation (read or writeback) is latched on grant and held until memory responds.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : cache_arbiter_if.slave, cache request/response and memory command signals
module cache_arbiter
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           reset,
    cache_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;
    grant_e     last_grant_q, last_grant_d;
    logic       d_op_write_q, d_op_write_d;

    logic i_req;
    logic d_req;

    assign i_req = bus.i_pmem_read;
    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantI;
            d_op_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            d_op_write_q <= d_op_write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        d_op_write_d = d_op_write_q;

        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.i_pmem_resp  = 1'b0;
        bus.d_pmem_resp  = 1'b0;
        bus.i_pmem_rdata = bus.pmem_rdata;
        bus.d_pmem_rdata = bus.pmem_rdata;

        case (state_q)
            StIdle: begin
                // A stray pmem_resp here is ignored: no response outputs are driven in idle.
                if (i_req || d_req) begin
                    // On a tie, serve the side that was not granted last time.
                    if (d_req && (!i_req || last_grant_q == GrantI)) begin
                        state_d      = StDServe;
                        last_grant_d = GrantD;
                        // Read and write together means writeback.
                        d_op_write_d = bus.d_pmem_write;
                    end else begin
                        state_d      = StIServe;
                        last_grant_d = GrantI;
                    end
                end
            end

            StIServe: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = bus.i_pmem_address;
                bus.i_pmem_resp  = bus.pmem_resp;
                if (bus.pmem_resp) begin
                    state_d = StIdle;
                end
            end

            StDServe: begin
                // Command comes from the latched op, so a dropped request cannot change it.
                bus.pmem_read    = ~d_op_write_q;
                bus.pmem_write   = d_op_write_q;
                bus.pmem_address = bus.d_pmem_address;
                bus.pmem_wdata   = bus.d_pmem_wdata;
                bus.d_pmem_resp  = bus.pmem_resp;
                if (bus.pmem_resp) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter. Expected memory transactions are queued when the
// cache requests are driven and popped when the arbiter issues a memory command.
module tb_cache_arbiter;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [15:0] addr;
        logic [127:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cache_arbiter_if bus ();

    cache_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drop_side(input bit is_d);
        if (is_d) begin
            bus.d_pmem_read  = 1'b0;
            bus.d_pmem_write = 1'b0;
        end else begin
            bus.i_pmem_read = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_rd"}, bus.pmem_read, 1'b0);
        check({tag, "_idle_wr"}, bus.pmem_write, 1'b0);
        check({tag, "_idle_addr"}, bus.pmem_address, 16'h0);
        check({tag, "_idle_wdata"}, bus.pmem_wdata, 128'h0);
    endtask

    // Wait for a memory command, compare it with the scoreboard head, hold it for lat
    // cycles, then respond with rdata and check the response is routed to the right side.
    task automatic serve(input string tag, input int lat, input logic [127:0] rdata,
                         input bit keep, input bit drop_mid, output int waits);
        exp_t e;
        bit   got;
        got   = 1'b0;
        waits = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            tick();
            #1;
            waits++;
            check({tag, "_excl"}, bus.pmem_read & bus.pmem_write, 1'b0);
            got = bus.pmem_read | bus.pmem_write;
        end
        check({tag, "_cmd_seen"}, got, 1'b1);
        if (!got) return;
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) tick();
            if (c == 1 && drop_mid) drop_side(e.is_d);
            if (c == lat) begin
                bus.pmem_rdata = rdata;
                bus.pmem_resp  = 1'b1;
            end
            #1;
            check({tag, "_rd"}, bus.pmem_read, !e.wr);
            check({tag, "_wr"}, bus.pmem_write, e.wr);
            check({tag, "_addr"}, bus.pmem_address, e.addr);
            if (e.wr) check({tag, "_wdata"}, bus.pmem_wdata, e.wdata);
            check({tag, "_i_resp"}, bus.i_pmem_resp, (c == lat) && !e.is_d);
            check({tag, "_d_resp"}, bus.d_pmem_resp, (c == lat) && e.is_d);
        end
        check({tag, "_i_rdata"}, bus.i_pmem_rdata, rdata);
        check({tag, "_d_rdata"}, bus.d_pmem_rdata, rdata);
        tick();
        bus.pmem_resp = 1'b0;
        if (!keep) drop_side(e.is_d);
        #1;
        check_idle(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int w;
        logic [127:0] wb_data;

        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = 16'h0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = 16'h0;
        bus.d_pmem_wdata   = 128'h0;
        bus.pmem_rdata     = 128'h0;
        bus.pmem_resp      = 1'b0;

        // Reset state, then a stray memory response while idle.
        do_reset();
        #1;
        check_idle("reset");
        check("reset_i_resp", bus.i_pmem_resp, 1'b0);
        check("reset_d_resp", bus.d_pmem_resp, 1'b0);
        bus.pmem_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        bus.pmem_resp  = 1'b1;
        #1;
        check("stray_i_resp", bus.i_pmem_resp, 1'b0);
        check("stray_d_resp", bus.d_pmem_resp, 1'b0);
        check("stray_i_rdata", bus.i_pmem_rdata, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        tick();
        bus.pmem_resp = 1'b0;
        #1;
        check_idle("stray");

        // Single I-cache fill: command one cycle after the request.
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h1230;
        sb.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h1230, wdata: 128'h0});
        #1;
        check("single_no_early_cmd", bus.pmem_read, 1'b0);
        serve("single", 1, {16{8'hA5}}, 1'b0, 1'b0, w);
        check("single_latency", w, 1);

        // First tie after reset goes to D; I follows two cycles after D's response.
        do_reset();
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h2220;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h4000;
        sb.push_back('{is_d: 1'b1, wr: 1'b0, addr: 16'h4000, wdata: 128'h0});
        sb.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h2220, wdata: 128'h0});
        serve("tie_d", 0, 128'hDDDD, 1'b0, 1'b0, w);
        check("tie_d_latency", w, 1);
        serve("tie_i", 0, 128'h1111, 1'b0, 1'b0, w);
        check("tie_i_latency", w, 1);

        // Continuous requests from both sides alternate D, I, D, I.
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h3330;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 16'h5550;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{is_d: 1'b1, wr: 1'b0, addr: 16'h5550, wdata: 128'h0});
            sb.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h3330, wdata: 128'h0});
        end
        serve("alt0_d", 1, 128'hA0, 1'b1, 1'b0, w);
        serve("alt1_i", 0, 128'hA1, 1'b1, 1'b0, w);
        serve("alt2_d", 2, 128'hA2, 1'b1, 1'b0, w);
        serve("alt3_i", 0, 128'hA3, 1'b0, 1'b0, w);
        bus.d_pmem_read = 1'b0;

        // D writeback with read+write both high; request dropped mid-service.
        wb_data            = {16{8'h0F}};
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 16'h6660;
        bus.d_pmem_wdata   = wb_data;
        sb.push_back('{is_d: 1'b1, wr: 1'b1, addr: 16'h6660, wdata: wb_data});
        serve("wb", 3, 128'h0, 1'b0, 1'b1, w);
        check("wb_latency", w, 1);

        // Reset during I service drops the in-flight response.
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 16'h7770;
        tick();
        #1;
        check("rst_mid_cmd", bus.pmem_read, 1'b1);
        check("rst_mid_addr", bus.pmem_address, 16'h7770);
        reset = 1'b1;
        tick();
        bus.pmem_rdata = 128'hBEEF;
        bus.pmem_resp  = 1'b1;
        #1;
        check("rst_mid_i_resp", bus.i_pmem_resp, 1'b0);
        check("rst_mid_rd", bus.pmem_read, 1'b0);
        reset           = 1'b0;
        bus.pmem_resp   = 1'b0;
        bus.i_pmem_read = 1'b0;
        tick();
        #1;
        check_idle("rst_mid_after");

        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
